// File: rtl/i2c_temp_responder.sv
// I2C target emulating an ADT7420: serves a 16-bit temperature snapshot and an ID byte through a byte-wide register pointer.
// Optional `define I2C_GLITCH_FILTER_EN adds a 3-sample majority filter after the SCL/SDA synchronisers.
module i2c_temp_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter logic [7:0] ID_VALUE = 8'hCB
) (
    input  logic        clk_fpga,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic        busy,
    output logic        addr_hit,
    output logic [7:0]  pointer
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_e;

    // Bit 1 carries SCL, bit 0 carries SDA through every conditioning stage.
    logic [1:0] s1_q, s1_d, s2_q, s2_d, hist_q, hist_d, lvl;
`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0][1:0] win_q, win_d;
    logic [1:0]      flt_q, flt_d;
`endif

    state_e      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;
    logic        phase_q, phase_d;
    logic [7:0]  tx_q, tx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [7:0]  pointer_q, pointer_d;
    logic        sda_oe_q, sda_oe_d;
    logic        addr_hit_q, addr_hit_d;

    logic scl_rise, scl_fall, start_ev, stop_ev, sda_bit;

    function automatic logic [7:0] read_map(input logic [7:0] ptr, input logic [15:0] snap);
        case (ptr)
            8'h00:   return snap[15:8];
            8'h01:   return snap[7:0];
            8'h0B:   return ID_VALUE;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        s1_d = {scl_in, sda_in};
        s2_d = s1_q;
`ifdef I2C_GLITCH_FILTER_EN
        win_d = {win_q[1:0], s2_q};
        flt_d = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
        lvl   = flt_q;
`else
        lvl   = s2_q;
`endif
        hist_d = lvl;
    end

    assign scl_rise = lvl[1] & ~hist_q[1];
    assign scl_fall = ~lvl[1] & hist_q[1];
    assign start_ev = lvl[1] & hist_q[1] & ~lvl[0] & hist_q[0];
    assign stop_ev  = lvl[1] & hist_q[1] & lvl[0] & ~hist_q[0];
    assign sda_bit  = lvl[0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // Synchroniser stages reset to the idle-high bus level so reset release never fakes a START/STOP.
    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= 2'b11;
            s2_q       <= 2'b11;
            hist_q     <= 2'b11;
`ifdef I2C_GLITCH_FILTER_EN
            win_q      <= '1;
            flt_q      <= 2'b11;
`endif
            state_q    <= IDLE;
            bitcnt_q   <= 3'd7;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            phase_q    <= 1'b0;
            tx_q       <= '0;
            shadow_q   <= '0;
            pointer_q  <= '0;
            sda_oe_q   <= 1'b0;
            addr_hit_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            hist_q     <= hist_d;
`ifdef I2C_GLITCH_FILTER_EN
            win_q      <= win_d;
            flt_q      <= flt_d;
`endif
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            phase_q    <= phase_d;
            tx_q       <= tx_d;
            shadow_q   <= shadow_d;
            pointer_q  <= pointer_d;
            sda_oe_q   <= sda_oe_d;
            addr_hit_q <= addr_hit_d;
        end
    end

    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        first_d    = first_q;
        phase_d    = phase_q;
        tx_d       = tx_q;
        shadow_d   = shadow_q;
        pointer_d  = pointer_q;
        sda_oe_d   = sda_oe_q;
        addr_hit_d = 1'b0;

        if (start_ev) begin
            state_d  = ADDR;
            bitcnt_d = 3'd7;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
        end else if (stop_ev) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, IGNORE: sda_oe_d = 1'b0;
                ADDR: if (scl_rise) begin
                    shift_d = {shift_q[5:0], sda_bit};
                    if (bitcnt_q == 3'd0) begin
                        if (shift_q == DEV_ADDR) begin
                            state_d    = ADDR_ACK;
                            addr_hit_d = 1'b1;
                            rw_d       = sda_bit;
                            first_d    = ~sda_bit;
                            phase_d    = 1'b0;
                            if (sda_bit) shadow_d = temp_in;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                // phase_q marks that the ACK is already on the bus; the second falling edge ends the slot.
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        bitcnt_d = 3'd7;
                        if (state_q == ADDR_ACK && rw_q) begin
                            state_d  = RD_BYTE;
                            tx_d     = read_map(pointer_q, shadow_q);
                            sda_oe_d = ~tx_d[7];
                        end else begin
                            state_d  = WR_BYTE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shift_d = {shift_q[5:0], sda_bit};
                    if (bitcnt_q == 3'd0) begin
                        state_d = WR_ACK;
                        phase_d = 1'b0;
                        if (first_q) begin
                            pointer_d = {shift_q, sda_bit};
                            first_d   = 1'b0;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                    end
                end
                // Here phase_q marks that the master has clocked in the last bit of the byte.
                RD_BYTE: if (scl_rise) begin
                    if (bitcnt_q == 3'd0) phase_d = 1'b1;
                    else                  bitcnt_d = bitcnt_q - 3'd1;
                end else if (scl_fall) begin
                    if (phase_q) begin
                        state_d  = RD_ACK;
                        phase_d  = 1'b0;
                        sda_oe_d = 1'b0;
                    end else begin
                        sda_oe_d = ~tx_q[bitcnt_q];
                    end
                end
                RD_ACK: if (scl_rise) begin
                    pointer_d = pointer_q + 8'd1;
                    if (sda_bit) state_d = IGNORE;
                    else         phase_d = 1'b1;
                end else if (scl_fall && phase_q) begin
                    state_d  = RD_BYTE;
                    phase_d  = 1'b0;
                    bitcnt_d = 3'd7;
                    tx_d     = read_map(pointer_q, shadow_q);
                    sda_oe_d = ~tx_d[7];
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sda_oe   = sda_oe_q;
        addr_hit = addr_hit_q;
        pointer  = pointer_q;
        busy     = state_q inside {ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK};
    end

endmodule

// File: tb/tb_i2c_temp_responder.sv
// Bench for i2c_temp_responder: bit-banged I2C master with directed and randomized transactions
// compared against a register-map model of the sensor.
module tb_i2c_temp_responder;

    localparam int Q = 10;

    logic        clk_fpga = 1'b0;
    logic        reset_n  = 1'b0;
    logic        scl      = 1'b1;
    logic        sda_m    = 1'b1;
    logic [15:0] temp_in  = 16'h0000;
    logic        sda_line;
    logic        sda_oe, busy, addr_hit;
    logic [7:0]  pointer;

    int checks   = 0;
    int failures = 0;
    int hit_cnt  = 0;
    int busy_cnt = 0;
    int exp_ptr  = 0;
    bit glitch_arm = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk_fpga = ~clk_fpga;

    i2c_temp_responder dut (
        .clk_fpga (clk_fpga),
        .reset_n  (reset_n),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .temp_in  (temp_in),
        .busy     (busy),
        .addr_hit (addr_hit),
        .pointer  (pointer)
    );

    always @(posedge clk_fpga) begin
        if (addr_hit === 1'b1) hit_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sensor register map as seen by a bus master.
    function automatic logic [7:0] ref_read(input int p, input logic [15:0] snap);
        if (p == 0)  return snap[15:8];
        if (p == 1)  return snap[7:0];
        if (p == 11) return 8'hCB;
        return 8'h00;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_fpga);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic clock_bit(input logic b, output logic rx);
        sda_m = b; wait_clk(Q);
        scl = 1'b1; wait_clk(Q / 2);
        if (glitch_arm) begin
            scl = 1'b0; wait_clk(1);
            scl = 1'b1;
            glitch_arm = 1'b0;
        end
        wait_clk(Q / 2);
        rx = sda_line; wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic rx;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], rx);
        clock_bit(1'b1, rx);
        ack = ~rx;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic rx;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, rx);
            b[i] = rx;
        end
        clock_bit(~ack, rx);
    endtask

    // Write transaction: first data byte sets the pointer, extra bytes are acknowledged and dropped.
    task automatic set_ptr(input logic [7:0] p, input int extra, input bit do_stop);
        logic a;
        bus_start();
        write_byte(8'h96, a);
        check("wr_addr_ack", 32'(a), 32'd1);
        write_byte(p, a);
        check("ptr_ack", 32'(a), 32'd1);
        exp_ptr = int'(p);
        for (int k = 0; k < extra; k++) begin
            write_byte(8'($urandom_range(0, 255)), a);
            check("extra_ack", 32'(a), 32'd1);
        end
        if (do_stop) begin
            bus_stop();
            check("ptr_after_write", 32'(pointer), 32'(exp_ptr));
        end
    endtask

    // Read n bytes; temp_in switches to t_after once the address byte is done.
    task automatic read_xfer(input int n, input logic [15:0] t_addr, input logic [15:0] t_after);
        logic a;
        logic [7:0] b;
        int hits0;
        hits0   = hit_cnt;
        temp_in = t_addr;
        bus_start();
        write_byte(8'h97, a);
        check("rd_addr_ack", 32'(a), 32'd1);
        temp_in = t_after;
        for (int k = 0; k < n; k++) begin
            read_byte(b, k < n - 1);
            check("rd_byte", 32'(b), 32'(ref_read(exp_ptr, t_addr)));
            exp_ptr = (exp_ptr + 1) % 256;
        end
        bus_stop();
        check("sda_rel_stop", 32'(sda_oe), 32'd0);
        check("ptr_after_read", 32'(pointer), 32'(exp_ptr));
        check("hit_once", 32'(hit_cnt - hits0), 32'd1);
    endtask

    initial begin
        logic a, rx;
        int hits0, busy0;
        logic [7:0] choices [5];

        wait_clk(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_hit", 32'(addr_hit), 32'd0);
        check("rst_pointer", 32'(pointer), 32'd0);
        reset_n = 1'b1;
        wait_clk(4 * Q);

        // Plain two-byte temperature read from pointer 0.
        read_xfer(2, 16'h0C80, 16'h0C80);

        // Pointer write, repeated START, ID read.
        set_ptr(8'h0B, 0, 1'b0);
        read_xfer(1, 16'h5A5A, 16'h5A5A);

        // Wrong address: no ACK, no hit, never busy.
        hits0 = hit_cnt;
        busy0 = busy_cnt;
        bus_start();
        write_byte(8'h90, a);
        check("bad_addr_nack", 32'(a), 32'd0);
        write_byte(8'h00, a);
        check("bad_data_nack", 32'(a), 32'd0);
        bus_stop();
        check("bad_no_hit", 32'(hit_cnt - hits0), 32'd0);
        check("bad_not_busy", 32'(busy_cnt - busy0), 32'd0);
        check("bad_ptr_kept", 32'(pointer), 32'(exp_ptr));

        // Coherent snapshot while temp_in changes mid-read.
        set_ptr(8'h00, 0, 1'b0);
        read_xfer(2, 16'h0C80, 16'h1234);

        // Pointer wrap 0xFF -> 0x00.
        set_ptr(8'hFF, 1, 1'b0);
        read_xfer(2, 16'hA1B2, 16'hA1B2);

        // Asynchronous reset while the target pulls SDA low on bit 4 of 0xCB.
        set_ptr(8'h0B, 0, 1'b0);
        bus_start();
        write_byte(8'h97, a);
        check("rst_seq_ack", 32'(a), 32'd1);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, rx);
        check("drive_before_rst", 32'(sda_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_release", 32'(sda_oe), 32'd0);
        check("rst_async_ptr", 32'(pointer), 32'd0);
        exp_ptr = 0;
        wait_clk(4);
        scl = 1'b1; sda_m = 1'b1;
        wait_clk(Q);
        reset_n = 1'b1;
        wait_clk(4 * Q);
        read_xfer(1, 16'h7E01, 16'h7E01);

`ifdef I2C_GLITCH_FILTER_EN
        // One-cycle SCL glitch while SCL is high must not disturb the byte.
        set_ptr(8'h0B, 0, 1'b0);
        glitch_arm = 1'b1;
        read_xfer(1, 16'h0000, 16'h0000);
`endif

        choices[0] = 8'h00; choices[1] = 8'h01; choices[2] = 8'h0B;
        choices[3] = 8'hFF; choices[4] = 8'h00;
        for (int it = 0; it < 20; it++) begin
            logic [15:0] t0, t1;
            logic [7:0]  p;
            int          pick;
            pick = int'($urandom_range(0, 5));
            p    = (pick == 5) ? 8'($urandom_range(0, 255)) : choices[pick];
            t0   = 16'($urandom_range(0, 65535));
            t1   = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 2))
                0: set_ptr(p, int'($urandom_range(0, 2)), 1'b1);
                1: begin
                    set_ptr(p, 0, 1'b0);
                    read_xfer(int'($urandom_range(1, 3)), t0, t1);
                end
                default: read_xfer(int'($urandom_range(1, 3)), t0, t1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
